// File: rtl/freq_pkg.sv
// Shared types and constants for the frequency-meter gate controller.
// Holds the FSM states, the gate range codes and the gate-length function.
package freq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        GATE   = 3'd2,
        SETTLE = 3'd3,
        LATCH  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        R_1S    = 2'd0,
        R_100MS = 2'd1,
        R_10MS  = 2'd2
    } range_t;

    // Gate length in clock cycles for range r: clk_hz / 10^r.
    function automatic int unsigned gate_len(input int unsigned clk_hz, input range_t r);
        case (r)
            R_100MS: return clk_hz / 10;
            R_10MS:  return clk_hz / 100;
            default: return clk_hz;
        endcase
    endfunction

endpackage

// File: rtl/freq_scale_sat.sv
// Scales a raw gate count to Hz (x10^r with shifts and adds) and clamps
// the result to the largest value the 6-digit display can show.
module freq_scale_sat
    import freq_pkg::*;
#(
    parameter int N           = 28,
    parameter int MAX_DISPLAY = 999_999
) (
    input  logic [N-1:0] count,
    input  logic [1:0]   range_code,
    output logic [N-1:0] freq,
    output logic         overflow
);

    localparam int W = N + 4;
    localparam logic [W-1:0] MAX_W = W'(MAX_DISPLAY);
    localparam logic [N-1:0] MAX_N = N'(MAX_DISPLAY);

    logic [W-1:0] wide;
    logic [W-1:0] scaled;

    function automatic logic [W-1:0] times10(input logic [W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

    // A raw count already above the limit can wrap the x100 path, so it
    // forces saturation on its own.
    always_comb begin
        wide = {4'b0000, count};
        case (range_code)
            R_1S:    scaled = wide;
            R_100MS: scaled = times10(wide);
            default: scaled = times10(times10(wide));
        endcase
        overflow = (wide > MAX_W) || (scaled > MAX_W);
        freq     = overflow ? MAX_N : scaled[N-1:0];
    end

endmodule

// File: rtl/freq_gate_controller.sv
// Gate-window sequencer for the frequency meter: clears and enables the edge
// counter for a precise gate, waits for it to settle, then latches the result in Hz.
module freq_gate_controller
    import freq_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int N             = 28,
    parameter int MAX_DISPLAY   = 999_999,
    parameter int SETTLE_CYCLES = 2,
    parameter int AUTO_HI       = 100_000,
    parameter int AUTO_LO       = 1_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic         continuous,
    input  logic         auto_range,
    input  logic [1:0]   range_sel,
    input  logic [N-1:0] count_in,
    output logic         cnt_clr,
    output logic         cnt_en,
    output logic [N-1:0] freq_out,
    output logic         freq_valid,
    output logic         overflow,
    output logic         busy,
    output logic [1:0]   range_used
);

    localparam int TIMER_MAX = (CLK_HZ > SETTLE_CYCLES) ? CLK_HZ : SETTLE_CYCLES;
    localparam int TW = $clog2(TIMER_MAX + 1);

    localparam logic [TW-1:0] G0_LAST     = TW'(gate_len(CLK_HZ, R_1S) - 1);
    localparam logic [TW-1:0] G1_LAST     = TW'(gate_len(CLK_HZ, R_100MS) - 1);
    localparam logic [TW-1:0] G2_LAST     = TW'(gate_len(CLK_HZ, R_10MS) - 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [N-1:0]  HI_N        = N'(AUTO_HI);
    localparam logic [N-1:0]  LO_N        = N'(AUTO_LO);

    state_t        state;
    state_t        next_state;
    logic [TW-1:0] timer;
    logic [TW-1:0] gate_last;
    logic          gate_done;
    logic          settle_done;
    range_t        auto_r;
    range_t        auto_r_next;
    range_t        sel_range;
    logic          cnt_clr_d;
    logic          cnt_en_d;
    logic          latch_ok;
    logic [N-1:0]  scaled;
    logic          scaled_ovf;

    freq_scale_sat #(
        .N           (N),
        .MAX_DISPLAY (MAX_DISPLAY)
    ) u_scale (
        .count      (count_in),
        .range_code (range_used),
        .freq       (scaled),
        .overflow   (scaled_ovf)
    );

    // One timer serves both GATE and SETTLE; it restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= next_state;
            timer <= (next_state != state) ? '0 : timer + 1'b1;
        end
    end

    always_comb begin
        case (range_used)
            2'd1:    gate_last = G1_LAST;
            2'd2:    gate_last = G2_LAST;
            default: gate_last = G0_LAST;
        endcase
        gate_done   = (timer == gate_last);
        settle_done = (timer == SETTLE_LAST);
    end

    always_comb begin
        next_state = state;
        if (stop) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = CLEAR;
                CLEAR:   next_state = GATE;
                GATE:    if (gate_done) next_state = SETTLE;
                SETTLE:  if (settle_done) next_state = LATCH;
                LATCH:   next_state = continuous ? CLEAR : IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Counter controls are decoded from the next state so they can be registered.
    always_comb begin
        cnt_clr_d = (next_state == CLEAR);
        cnt_en_d  = (next_state == GATE);
        latch_ok  = (state == LATCH) && !stop;

        if (auto_range)
            sel_range = auto_r;
        else if (range_sel == 2'd3)
            sel_range = R_10MS;
        else
            sel_range = range_t'(range_sel);

        auto_r_next = auto_r;
        if ((count_in >= HI_N) && (auto_r != R_10MS))
            auto_r_next = range_t'(auto_r + 2'd1);
        else if ((count_in < LO_N) && (auto_r != R_1S))
            auto_r_next = range_t'(auto_r - 2'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_clr    <= 1'b0;
            cnt_en     <= 1'b0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
            range_used <= 2'd0;
            auto_r     <= R_1S;
        end else begin
            cnt_clr    <= cnt_clr_d;
            cnt_en     <= cnt_en_d;
            freq_valid <= latch_ok;
            if (state == CLEAR)
                range_used <= sel_range;
            if (latch_ok) begin
                freq_out <= scaled;
                overflow <= scaled_ovf;
                auto_r   <= auto_r_next;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_freq_gate_controller.sv
// Directed self-checking bench for freq_gate_controller with a 1 kHz clock
// parameter, so the 1 s gate is 1000 cycles long.
module tb_freq_gate_controller;

    localparam int CLK_HZ = 1000;
    localparam int N      = 28;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         stop;
    logic         continuous;
    logic         auto_range;
    logic [1:0]   range_sel;
    logic [N-1:0] count_in;
    logic         cnt_clr;
    logic         cnt_en;
    logic [N-1:0] freq_out;
    logic         freq_valid;
    logic         overflow;
    logic         busy;
    logic [1:0]   range_used;

    int total  = 0;
    int passed = 0;

    int          en_cnt;
    int          clr_cnt;
    int          valid_cnt;
    int          first_en;
    int          first_idle;
    int          valid_cyc[$];
    int          gate_rng[$];
    logic [31:0] cap_freq;
    logic [31:0] cap_ovf;
    bit          prev_en;

    always #5 clk = ~clk;

    freq_gate_controller #(
        .CLK_HZ (CLK_HZ),
        .N      (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .auto_range (auto_range),
        .range_sel  (range_sel),
        .count_in   (count_in),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .freq_out   (freq_out),
        .freq_valid (freq_valid),
        .overflow   (overflow),
        .busy       (busy),
        .range_used (range_used)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp)
            passed++;
        else
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit p, input bit cont, input bit ar,
                                 input logic [1:0] rs, input logic [N-1:0] cnt);
        start      = s;
        stop       = p;
        continuous = cont;
        auto_range = ar;
        range_sel  = rs;
        count_in   = cnt;
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) waitCycle();
        rst = 1'b0;
    endtask

    // Optionally pulses start for one cycle, then records what the DUT does
    // over a fixed number of cycles; cycle 1 is the one after start is sampled.
    task automatic watch(input bit do_start, input int cycles);
        en_cnt     = 0;
        clr_cnt    = 0;
        valid_cnt  = 0;
        first_en   = -1;
        first_idle = -1;
        cap_freq   = 0;
        cap_ovf    = 0;
        prev_en    = 1'b0;
        valid_cyc.delete();
        gate_rng.delete();
        if (do_start) start = 1'b1;
        for (int c = 1; c <= cycles; c++) begin
            waitCycle();
            if (do_start && c == 1) start = 1'b0;
            if (cnt_en) begin
                en_cnt++;
                if (!prev_en) begin
                    gate_rng.push_back(int'(range_used));
                    if (first_en < 0) first_en = c;
                end
            end
            prev_en = cnt_en;
            if (cnt_clr) clr_cnt++;
            if (freq_valid) begin
                valid_cnt++;
                valid_cyc.push_back(c);
                cap_freq = 32'(freq_out);
                cap_ovf  = 32'(overflow);
            end
            if (!busy && first_idle < 0) first_idle = c;
        end
    endtask

    function automatic int firstRange();
        return (gate_rng.size() > 0) ? gate_rng[0] : -1;
    endfunction

    function automatic int validAt(input int idx);
        return (valid_cyc.size() > idx) ? valid_cyc[idx] : -1;
    endfunction

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 2'd0, '0);
        repeat (3) waitCycle();
        checkOutput("rst cnt_clr", 32'(cnt_clr), 0);
        checkOutput("rst cnt_en", 32'(cnt_en), 0);
        checkOutput("rst freq_out", 32'(freq_out), 0);
        checkOutput("rst freq_valid", 32'(freq_valid), 0);
        checkOutput("rst overflow", 32'(overflow), 0);
        checkOutput("rst busy", 32'(busy), 0);
        checkOutput("rst range_used", 32'(range_used), 0);
        rst = 1'b0;
        waitCycle();

        $display("[TB] 1 s gate, count 37");
        applyStimulus(0, 0, 0, 0, 2'd0, 28'd37);
        watch(1, 1010);
        checkOutput("t1 clr pulses", clr_cnt, 1);
        checkOutput("t1 first en cycle", first_en, 2);
        checkOutput("t1 en cycles", en_cnt, 1000);
        checkOutput("t1 valid pulses", valid_cnt, 1);
        checkOutput("t1 valid cycle", validAt(0), 1005);
        checkOutput("t1 freq", cap_freq, 37);
        checkOutput("t1 ovf", cap_ovf, 0);
        checkOutput("t1 idle cycle", first_idle, 1005);
        checkOutput("t1 range", firstRange(), 0);

        $display("[TB] 10 ms gate, saturating and not");
        applyStimulus(0, 0, 0, 0, 2'd2, 28'd12_345);
        watch(1, 20);
        checkOutput("t2a en cycles", en_cnt, 10);
        checkOutput("t2a valid cycle", validAt(0), 15);
        checkOutput("t2a freq", cap_freq, 999_999);
        checkOutput("t2a ovf", cap_ovf, 1);
        checkOutput("t2a range", firstRange(), 2);
        applyStimulus(0, 0, 0, 0, 2'd2, 28'd4_321);
        watch(1, 20);
        checkOutput("t2b freq", cap_freq, 432_100);
        checkOutput("t2b ovf", cap_ovf, 0);
        applyStimulus(0, 0, 0, 0, 2'd3, 28'd7);
        watch(1, 20);
        checkOutput("t2c range3 en cycles", en_cnt, 10);
        checkOutput("t2c range3 used", firstRange(), 2);
        checkOutput("t2c range3 freq", cap_freq, 700);

        $display("[TB] range_sel change mid-gate is ignored");
        applyStimulus(1, 0, 0, 0, 2'd2, 28'd5);
        waitCycle();
        start = 1'b0;
        repeat (2) waitCycle();
        range_sel = 2'd0;
        watch(0, 15);
        checkOutput("t2d en cycles", en_cnt, 8);
        checkOutput("t2d valid cycle", validAt(0), 12);
        checkOutput("t2d freq", cap_freq, 500);
        checkOutput("t2d range", 32'(range_used), 2);

        $display("[TB] continuous mode");
        applyStimulus(0, 0, 1, 0, 2'd2, 28'd50);
        watch(1, 45);
        checkOutput("t3 valid pulses", valid_cnt, 3);
        checkOutput("t3 first valid", validAt(0), 15);
        checkOutput("t3 gap 1", validAt(1) - validAt(0), 14);
        checkOutput("t3 gap 2", validAt(2) - validAt(1), 14);
        checkOutput("t3 clr pulses", clr_cnt, 4);
        checkOutput("t3 never idle", first_idle, -1);
        checkOutput("t3 freq", cap_freq, 5_000);
        applyStimulus(0, 1, 0, 0, 2'd2, 28'd50);
        waitCycle();
        checkOutput("t3 stop busy", 32'(busy), 0);
        checkOutput("t3 stop cnt_en", 32'(cnt_en), 0);
        stop = 1'b0;

        $display("[TB] auto-range");
        doReset();
        applyStimulus(0, 0, 0, 1, 2'd2, 28'd150_000);
        watch(1, 1010);
        checkOutput("t4a range", firstRange(), 0);
        checkOutput("t4a en cycles", en_cnt, 1000);
        checkOutput("t4a freq", cap_freq, 150_000);
        checkOutput("t4a ovf", cap_ovf, 0);
        watch(1, 110);
        checkOutput("t4b range", firstRange(), 1);
        checkOutput("t4b en cycles", en_cnt, 100);
        checkOutput("t4b freq", cap_freq, 999_999);
        checkOutput("t4b ovf", cap_ovf, 1);
        count_in = 28'd500;
        watch(1, 20);
        checkOutput("t4c range", firstRange(), 2);
        checkOutput("t4c freq", cap_freq, 50_000);
        count_in = 28'd2_000;
        watch(1, 110);
        checkOutput("t4d range", firstRange(), 1);
        checkOutput("t4d en cycles", en_cnt, 100);
        checkOutput("t4d freq", cap_freq, 20_000);

        $display("[TB] stop during gate");
        applyStimulus(0, 0, 0, 0, 2'd0, 28'd77);
        watch(1, 401);
        checkOutput("t5 en before stop", en_cnt, 400);
        stop = 1'b1;
        waitCycle();
        checkOutput("t5 cnt_en after stop", 32'(cnt_en), 0);
        checkOutput("t5 busy after stop", 32'(busy), 0);
        stop = 1'b0;
        watch(0, 1100);
        checkOutput("t5 no valid", valid_cnt, 0);
        checkOutput("t5 no en", en_cnt, 0);
        checkOutput("t5 freq kept", 32'(freq_out), 20_000);
        checkOutput("t5 ovf kept", 32'(overflow), 0);
        applyStimulus(1, 1, 0, 0, 2'd0, 28'd77);
        waitCycle();
        checkOutput("t5 start+stop busy", 32'(busy), 0);
        checkOutput("t5 start+stop clr", 32'(cnt_clr), 0);
        waitCycle();
        checkOutput("t5 start+stop busy 2", 32'(busy), 0);
        applyStimulus(0, 0, 0, 0, 2'd0, 28'd77);

        $display("[TB] reset during settle");
        applyStimulus(0, 0, 0, 0, 2'd2, 28'd4_321);
        watch(1, 12);
        checkOutput("t6 in settle busy", 32'(busy), 1);
        rst = 1'b1;
        waitCycle();
        checkOutput("t6 rst freq_out", 32'(freq_out), 0);
        checkOutput("t6 rst overflow", 32'(overflow), 0);
        checkOutput("t6 rst range_used", 32'(range_used), 0);
        checkOutput("t6 rst busy", 32'(busy), 0);
        checkOutput("t6 rst cnt_en", 32'(cnt_en), 0);
        checkOutput("t6 rst cnt_clr", 32'(cnt_clr), 0);
        checkOutput("t6 rst freq_valid", 32'(freq_valid), 0);
        rst = 1'b0;
        watch(1, 20);
        checkOutput("t6 rerun valid cycle", validAt(0), 15);
        checkOutput("t6 rerun freq", cap_freq, 432_100);
        checkOutput("t6 rerun ovf", cap_ovf, 0);
        checkOutput("t6 rerun range", firstRange(), 2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
